avalon_s_burst_ram: RTL

Parametrised Avalon-MM burst slave with internal word-addressed RAM, used as the synthesizable memory endpoint behind the curl Avalon fabric and as a DUT-side responder for slave-interface agents. It generalises the fixed 1024-bit / 11-bit-burst slave port to configurable data width, depth, burst width and read pipeline latency. It adds burst write/read sequencing with a state machine, byte-enable masking and a fixed-latency readdatavalid pipeline.

---
 rtl/avalon_s_burst_ram_if.sv | 34 +++
 rtl/avalon_s_burst_ram.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/avalon_s_burst_ram_if.sv
// Avalon-MM burst bus bundle between a master and avalon_s_burst_ram.
//   master modport : drives address/byteenable/chipselect/read/write/
//                    writedata/burstcount/beginbursttransfer,
//                    receives readdata/waitrequest/readdatavalid.
//   slave modport  : the mirror image.
interface avalon_s_burst_ram_if #(
    parameter int DATA_W  = 1024,
    parameter int ADDR_W  = 32,
    parameter int BURST_W = 11
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [BURST_W-1:0]  burstcount;
    logic                beginbursttransfer;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;
    logic                readdatavalid;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
               burstcount, beginbursttransfer,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
               burstcount, beginbursttransfer,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/avalon_s_burst_ram.sv
// Avalon-MM burst slave backed by an internal word-addressed RAM.
// Write bursts complete with zero latency (one beat per chipselect&write
// cycle, gaps allowed); read bursts stall the bus with waitrequest while
// N back-to-back RAM reads are issued and returned READ_LAT cycles later
// on readdatavalid. Word indices wrap modulo the RAM depth.
// Ports:
//   clk  : clock, rising edge
//   arst : synchronous active-high reset (clears FSM, counters, read pipe;
//          RAM contents are kept)
//   s    : Avalon-MM slave bus (avalon_s_burst_ram_if.slave)
module avalon_s_burst_ram #(
    parameter int DATA_W     = 1024,
    parameter int ADDR_W     = 32,
    parameter int BURST_W    = 11,
    parameter int DEPTH_LOG2 = 8,
    parameter int READ_LAT   = 2
) (
    input  logic             clk,
    input  logic             arst,
    avalon_s_burst_ram_if.slave s
);
    localparam int BE_W  = DATA_W / 8;
    localparam int LSB   = $clog2(BE_W);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;
    typedef logic [DEPTH_LOG2-1:0] idx_t;
    typedef logic [BURST_W-1:0]    cnt_t;

    state_t state_q, state_d;
    idx_t   wr_idx_q, wr_idx_d;
    cnt_t   wr_left_q, wr_left_d;
    idx_t   rd_idx_q, rd_idx_d;
    cnt_t   issue_left_q, issue_left_d;
    cnt_t   rtn_left_q, rtn_left_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic              mem_re;
    idx_t              mem_widx;
    idx_t              mem_ridx;

    idx_t              req_idx;
    cnt_t              req_len;
    logic              rdv_out;
    logic [DATA_W-1:0] rdata_out;

    // Address bits outside the word index and beginbursttransfer carry no
    // meaning for this slave.
    logic unused_inputs;
    assign unused_inputs = ^{s.address, s.beginbursttransfer};

    assign req_idx = s.address[LSB +: DEPTH_LOG2];
    // A zero burstcount behaves as a single beat.
    assign req_len = (s.burstcount == '0) ? cnt_t'(1) : s.burstcount;

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        wr_left_d    = wr_left_q;
        rd_idx_d     = rd_idx_q;
        issue_left_d = issue_left_q;
        rtn_left_d   = rtn_left_q;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_widx     = wr_idx_q;
        mem_ridx     = rd_idx_q;

        case (state_q)
            IDLE: begin
                // write has priority; a simultaneous read is dropped
                if (s.chipselect && s.write) begin
                    mem_we    = 1'b1;
                    mem_widx  = req_idx;
                    wr_idx_d  = idx_t'(req_idx + 1'b1);
                    wr_left_d = cnt_t'(req_len - 1'b1);
                    if (req_len != cnt_t'(1)) begin
                        state_d = WR_BURST;
                    end
                end else if (s.chipselect && s.read) begin
                    // beat 0 is issued in the accept cycle itself
                    mem_re       = 1'b1;
                    mem_ridx     = req_idx;
                    rd_idx_d     = idx_t'(req_idx + 1'b1);
                    issue_left_d = cnt_t'(req_len - 1'b1);
                    rtn_left_d   = req_len;
                    state_d      = RD_BURST;
                end
            end
            WR_BURST: begin
                if (s.chipselect && s.write) begin
                    mem_we    = 1'b1;
                    wr_idx_d  = idx_t'(wr_idx_q + 1'b1);
                    wr_left_d = cnt_t'(wr_left_q - 1'b1);
                    if (wr_left_q == cnt_t'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_BURST: begin
                if (issue_left_q != '0) begin
                    mem_re       = 1'b1;
                    rd_idx_d     = idx_t'(rd_idx_q + 1'b1);
                    issue_left_d = cnt_t'(issue_left_q - 1'b1);
                end
                if (rdv_out) begin
                    rtn_left_d = cnt_t'(rtn_left_q - 1'b1);
                    if (rtn_left_q == cnt_t'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q      <= IDLE;
            wr_idx_q     <= '0;
            wr_left_q    <= '0;
            rd_idx_q     <= '0;
            issue_left_q <= '0;
            rtn_left_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            wr_left_q    <= wr_left_d;
            rd_idx_q     <= rd_idx_d;
            issue_left_q <= issue_left_d;
            rtn_left_q   <= rtn_left_d;
        end
    end

    // RAM write port with per-byte enables; blocked while in reset so a
    // request presented during reset leaves the memory untouched.
    always_ff @(posedge clk) begin
        if (mem_we && !arst) begin
            for (int b = 0; b < BE_W; b++) begin
                if (s.byteenable[b]) begin
                    mem[mem_widx][b*8 +: 8] <= s.writedata[b*8 +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 is the registered RAM output, later stages
    // pad the latency to READ_LAT. Each data stage only loads when its
    // input is valid, so readdata holds between beats.
    for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_stage
        logic [DATA_W-1:0] data_q;
        logic              vld_q;
        if (gi == 0) begin : g_ram
            always_ff @(posedge clk) begin
                if (arst) begin
                    vld_q  <= 1'b0;
                    data_q <= '0;
                end else begin
                    vld_q <= mem_re;
                    if (mem_re) begin
                        data_q <= mem[mem_ridx];
                    end
                end
            end
        end else begin : g_dly
            always_ff @(posedge clk) begin
                if (arst) begin
                    vld_q  <= 1'b0;
                    data_q <= '0;
                end else begin
                    vld_q <= g_stage[gi-1].vld_q;
                    if (g_stage[gi-1].vld_q) begin
                        data_q <= g_stage[gi-1].data_q;
                    end
                end
            end
        end
    end

    assign rdv_out   = g_stage[READ_LAT-1].vld_q;
    assign rdata_out = g_stage[READ_LAT-1].data_q;

    assign s.readdata      = rdata_out;
    assign s.readdatavalid = rdv_out;
    // stalled for the whole read burst, and unconditionally during reset
    assign s.waitrequest   = arst || (state_q == RD_BURST);
endmodule
